// File: rtl/ccg_lut_eval.sv
// ccg_lut_eval: loadable truth-table evaluator.
// Rows load over cfg_*, then x is evaluated into a registered f.
module ccg_lut_eval #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [N_OUT-1:0] cfg_data,
  output logic             cfg_ready,
  input  logic [N_IN-1:0]  x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [N_OUT-1:0] f,
  output logic             f_valid,
  input  logic             f_ready,
  output logic             loaded,
  output logic [15:0]      eval_cnt
);

  localparam int ROWS = 1 << N_IN;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } state_t;

  state_t           state;
  logic [N_IN-1:0]  ptr;
  logic [N_OUT-1:0] tbl [ROWS];

  logic start_ok;
  logic wr_en;
  logic x_acc;

  // A start is dropped while a result is still waiting in RUN.
  assign start_ok  = cfg_start && (state != RUN || !f_valid);
  assign wr_en     = (state == LOAD) && cfg_valid && !cfg_start;
  assign cfg_ready = (state == LOAD);
  assign x_ready   = (state == RUN) && (!f_valid || f_ready);
  assign x_acc     = x_valid && x_ready;

  // Load sequencing: EMPTY/LOAD/RUN, row pointer and loaded flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      ptr    <= '0;
      loaded <= 1'b0;
    end else if (start_ok) begin
      state  <= LOAD;
      ptr    <= '0;
      loaded <= 1'b0;
    end else if (wr_en) begin
      if (&ptr) begin
        state  <= RUN;
        ptr    <= '0;
        loaded <= 1'b1;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // Table storage; old rows survive a reload until rewritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        tbl[i] <= '0;
      end
    end else if (wr_en) begin
      tbl[ptr] <= cfg_data;
    end
  end

  // Output register with hold-under-backpressure and no-bubble refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f       <= '0;
      f_valid <= 1'b0;
    end else if (x_acc) begin
      f       <= tbl[x];
      f_valid <= 1'b1;
    end else if (f_ready) begin
      f_valid <= 1'b0;
    end
  end

  // Saturating count of accepted evaluations, cleared by a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_cnt <= '0;
    end else if (start_ok) begin
      eval_cnt <= '0;
    end else if (x_acc && !(&eval_cnt)) begin
      eval_cnt <= eval_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ccg_lut_eval.sv
// tb_ccg_lut_eval: randomized and directed checks of ccg_lut_eval
// against a behavioural model of the table evaluator.
module tb_ccg_lut_eval;

  localparam int NI   = 3;
  localparam int NO   = 10;
  localparam int ROWS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [NO-1:0] cfg_data = '0;
  logic [NI-1:0] x = '0;
  logic          x_valid = 1'b0;
  logic          f_ready = 1'b0;
  logic          cfg_ready;
  logic          x_ready;
  logic [NO-1:0] f;
  logic          f_valid;
  logic          loaded;
  logic [15:0]   eval_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ccg_lut_eval #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .x(x),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .f(f),
    .f_valid(f_valid),
    .f_ready(f_ready),
    .loaded(loaded),
    .eval_cnt(eval_cnt)
  );

  // Behavioural model: mode 0 = empty, 1 = loading, 2 = running.
  int          m_mode = 0;
  int          m_ptr = 0;
  int          m_tbl [ROWS];
  int          m_f = 0;
  bit          m_fv = 0;
  bit          m_loaded = 0;
  int          m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    bit acc_s;
    bit acc_x;
    if (rst) begin
      m_mode = 0;
      m_ptr = 0;
      foreach (m_tbl[i]) m_tbl[i] = 0;
      m_f = 0;
      m_fv = 0;
      m_loaded = 0;
      m_cnt = 0;
    end else begin
      acc_s = cfg_start && (m_mode != 2 || !m_fv);
      acc_x = x_valid && m_mode == 2 && (!m_fv || f_ready);
      if (acc_x) begin
        m_f = m_tbl[int'(x)];
        m_fv = 1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (f_ready) begin
        m_fv = 0;
      end
      if (acc_s) begin
        m_mode = 1;
        m_ptr = 0;
        m_loaded = 0;
        m_cnt = 0;
      end else if (m_mode == 1 && cfg_valid) begin
        m_tbl[m_ptr] = int'(cfg_data);
        m_ptr = m_ptr + 1;
        if (m_ptr == ROWS) begin
          m_mode = 2;
          m_loaded = 1;
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every negative edge, all outputs against the model.
  always @(negedge clk) begin
    check("f", int'(f), m_f);
    check("f_valid", int'(f_valid), int'(m_fv));
    check("loaded", int'(loaded), int'(m_loaded));
    check("eval_cnt", int'(eval_cnt), m_cnt);
    check("cfg_ready", int'(cfg_ready), int'(m_mode == 1));
    check("x_ready", int'(x_ready),
          int'(m_mode == 2 && (!m_fv || f_ready)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_start = 0;
    cfg_valid = 0;
    x_valid = 0;
  endtask

  task automatic load_rand();
    cfg_start = 1;
    tick();
    cfg_start = 0;
    cfg_valid = 1;
    for (int i = 0; i < ROWS; i++) begin
      cfg_data = NO'($urandom);
      tick();
    end
    cfg_valid = 0;
  endtask

  initial begin
    int r;
    // Reset state
    tick();
    tick();
    check("rst_f_valid", int'(f_valid), 0);
    check("rst_x_ready", int'(x_ready), 0);
    check("rst_cnt", int'(eval_cnt), 0);
    rst = 0;

    // No evaluation before a table is loaded
    x = 3;
    x_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_x_ready", int'(x_ready), 0);
      check("empty_f_valid", int'(f_valid), 0);
      check("empty_cnt", int'(eval_cnt), 0);
    end
    x_valid = 0;

    // Load row[i] = 3*i+1, then evaluate x=5
    cfg_start = 1;
    tick();
    cfg_start = 0;
    cfg_valid = 1;
    for (int i = 0; i < ROWS; i++) begin
      cfg_data = NO'(i * 3 + 1);
      check("pre_loaded", int'(loaded), 0);
      tick();
    end
    cfg_valid = 0;
    check("loaded_lit", int'(loaded), 1);
    f_ready = 1;
    x = 5;
    x_valid = 1;
    tick();
    x_valid = 0;
    check("f5_lit", int'(f), 16);
    check("fv5_lit", int'(f_valid), 1);
    check("cnt1_lit", int'(eval_cnt), 1);

    // Full throughput sweep; count continues from the x=5 eval
    for (int i = 0; i < ROWS; i++) begin
      x = NI'(i);
      x_valid = 1;
      tick();
      check("sweep_lit", int'(f), i * 3 + 1);
    end
    x_valid = 0;
    check("cnt9_lit", int'(eval_cnt), 9);
    tick();

    // Backpressure hold, then consume+accept in one cycle
    f_ready = 0;
    x = 3;
    x_valid = 1;
    tick();
    x_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_f_lit", int'(f), 10);
      check("hold_xr_lit", int'(x_ready), 0);
    end
    f_ready = 1;
    x = 2;
    x_valid = 1;
    tick();
    x_valid = 0;
    check("refill_f_lit", int'(f), 7);
    check("refill_fv_lit", int'(f_valid), 1);
    tick();

    // Restart mid-load, then all rows 3FF
    cfg_start = 1;
    tick();
    cfg_start = 0;
    cfg_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cfg_data = NO'($urandom);
      tick();
    end
    cfg_start = 1;
    cfg_data = '0;
    tick();
    cfg_start = 0;
    cfg_data = 10'h3FF;
    for (int i = 0; i < ROWS; i++) tick();
    cfg_valid = 0;
    for (int i = 0; i < ROWS; i++) begin
      x = NI'(i);
      x_valid = 1;
      tick();
      check("all3ff_lit", int'(f), 'h3FF);
    end
    x_valid = 0;
    f_ready = 0;
    x = 0;
    x_valid = 1;
    tick();
    x_valid = 0;
    cfg_start = 1;
    tick();
    cfg_start = 0;
    check("ign_start_loaded", int'(loaded), 1);
    check("ign_start_cfgr", int'(cfg_ready), 0);
    f_ready = 1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 99));
      x = NI'($urandom);
      x_valid = $urandom_range(0, 3) != 0;
      f_ready = $urandom_range(0, 2) != 0;
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_data = NO'($urandom);
      cfg_start = (r < 3) && !x_valid;
      tick();
    end
    idle();
    f_ready = 1;
    tick();

    // Reset mid-load discards progress
    cfg_start = 1;
    tick();
    cfg_start = 0;
    cfg_valid = 1;
    for (int i = 0; i < 5; i++) begin
      cfg_data = NO'($urandom);
      tick();
    end
    cfg_valid = 0;
    rst = 1;
    #1;
    check("arst_loaded", int'(loaded), 0);
    check("arst_xr", int'(x_ready), 0);
    check("arst_cfgr", int'(cfg_ready), 0);
    check("arst_cnt", int'(eval_cnt), 0);
    tick();
    rst = 0;
    x_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_xr", int'(x_ready), 0);
    end
    x_valid = 0;

    // Saturate eval_cnt
    load_rand();
    f_ready = 1;
    x_valid = 1;
    for (int i = 0; i < 65540; i++) begin
      x = NI'($urandom);
      tick();
    end
    check("sat_lit", int'(eval_cnt), 'hFFFF);
    tick();
    check("sat_hold_lit", int'(eval_cnt), 'hFFFF);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
